// File: rtl/uart_recv_postprocess_pkg.sv
// Shared definitions for the UART receive post-processing block.
//   UART_DATA_W          received byte width
//   DEF_*                default FIFO geometry, IRQ threshold and idle timeout
//   uart_byte_t          one received byte
//   rx_event_e           classification of an incoming RX strobe
package uart_recv_postprocess_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned DEF_PTR_WIDTH      = 6;
  localparam int unsigned DEF_FIFO_DEPTH     = 64;
  localparam int unsigned DEF_RX_THRESH      = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 5000;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  // What happens to the byte offered by the RX core in the current cycle.
  typedef enum logic [1:0] {
    RxNone,  // no strobe
    RxPush,  // byte written into the FIFO
    RxDrop,  // FIFO full and not draining: byte lost (overrun)
    RxFerr   // bad stop bit: byte discarded
  } rx_event_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous fall-through FIFO for received bytes.
//   clk        system clock, posedge
//   rst        synchronous active-high reset (pointers and count cleared)
//   push       write wr_data (ignored when full unless pop is also set)
//   wr_data    byte to write
//   pop        advance the read pointer (ignored when empty)
//   rd_data    byte at the read pointer, combinational
//   full       count == FIFO_DEPTH
//   empty      count == 0
//   count      fill level 0..FIFO_DEPTH
// FIFO_DEPTH must equal 2**PTR_WIDTH so the pointers wrap naturally.
module uart_rx_fifo
  import uart_recv_postprocess_pkg::*;
#(
  parameter int unsigned PTR_WIDTH  = DEF_PTR_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  uart_byte_t         wr_data,
  input  logic               pop,
  output uart_byte_t         rd_data,
  output logic               full,
  output logic               empty,
  output logic [PTR_WIDTH:0] count
);

  localparam logic [PTR_WIDTH:0] DepthCnt = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] OneCnt   = (PTR_WIDTH + 1)'(1);

  uart_byte_t mem [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 wr_en, rd_en;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rptr_q];

  // A push into a full FIFO is legal only while the head is leaving.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + OneCnt;
      2'b01:   count_d = count_q - OneCnt;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_recv_postprocess.sv
// Receive-side buffer between the UART RX core and the APB register block.
// Byte strobes from the RX core are queued in a fall-through FIFO whose head
// is presented to APB reads. Overrun and frame errors raise sticky flags and
// irq_rx is a registered level interrupt at a fill threshold.
//   sys_clk, sys_rst          clock and synchronous active-high reset
//   rx_valid/rx_data          one-cycle byte strobe from the RX core
//   rx_frame_err              qualifies rx_valid: stop bit was bad
//   apb_ren                   pop the head byte
//   apb_rdata/apb_rvalid      head byte (0 when empty) / FIFO not empty
//   apb_clr_err               clear rx_overrun and rx_ferr
//   rx_count                  fill level 0..FIFO_DEPTH
//   rx_overrun/rx_ferr        sticky error flags
//   irq_rx                    count >= RX_THRESH (or idle timeout)
// Optional: define UART_RX_TIMEOUT_EN to add an idle timeout that also raises
// irq_rx when a short tail sits below the threshold for TIMEOUT_CYCLES.
module uart_recv_postprocess
  import uart_recv_postprocess_pkg::*;
#(
  parameter int unsigned PTR_WIDTH      = DEF_PTR_WIDTH,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned RX_THRESH      = DEF_RX_THRESH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_frame_err,
  input  logic                 apb_ren,
  output logic [7:0]           apb_rdata,
  output logic                 apb_rvalid,
  input  logic                 apb_clr_err,
  output logic [PTR_WIDTH:0]   rx_count,
  output logic                 rx_overrun,
  output logic                 rx_ferr,
  output logic                 irq_rx
);

  localparam logic [PTR_WIDTH:0] ThreshCnt = (PTR_WIDTH + 1)'(RX_THRESH);
  localparam logic [PTR_WIDTH:0] OneCnt    = (PTR_WIDTH + 1)'(1);

  rx_event_e          rx_event;
  logic               push, pop;
  logic               full, empty;
  logic [PTR_WIDTH:0] count, count_next;
  uart_byte_t         head;

  logic overrun_q, overrun_d;
  logic ferr_q, ferr_d;
  logic irq_q, irq_d;
  logic timeout_next;

  uart_rx_fifo #(
    .PTR_WIDTH  (PTR_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (push),
    .wr_data (rx_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Classify the incoming strobe. A pop frees a slot in the same cycle, so a
  // full FIFO that is also being read still accepts the new byte.
  always_comb begin
    pop      = apb_ren & ~empty;
    rx_event = RxNone;
    if (rx_valid) begin
      if (rx_frame_err)     rx_event = RxFerr;
      else if (full & ~pop) rx_event = RxDrop;
      else                  rx_event = RxPush;
    end
    push = (rx_event == RxPush);
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_next = count + OneCnt;
      2'b01:   count_next = count - OneCnt;
      default: count_next = count;
    endcase
  end

  // Sticky flags: a new error wins over a clear in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    if (apb_clr_err) begin
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
    if (rx_event == RxDrop) overrun_d = 1'b1;
    if (rx_event == RxFerr) ferr_d    = 1'b1;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYCLES);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;

  // Counts quiet cycles while data is waiting; any FIFO traffic restarts it.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (push | pop) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (empty) begin
      idle_d    = '0;
    end else begin
      if (idle_q != IdleMax) idle_d = idle_q + 1'b1;
      if (idle_d == IdleMax) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_next = timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_next       = 1'b0;
`endif

  // Registered against next-cycle state so irq_rx tracks rx_count edge for edge.
  assign irq_d = (count_next >= ThreshCnt) | timeout_next;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      irq_q     <= irq_d;
    end
  end

  assign apb_rvalid = ~empty;
  assign apb_rdata  = empty ? 8'h00 : head;
  assign rx_count   = count;
  assign rx_overrun = overrun_q;
  assign rx_ferr    = ferr_q;
  assign irq_rx     = irq_q;

endmodule

// File: tb/tb_uart_recv_postprocess.sv
// Directed self-checking bench for uart_recv_postprocess (PTR_WIDTH=6,
// depth 64, RX_THRESH=8, TIMEOUT_CYCLES=100). Inputs change 1ns after the
// rising edge; outputs are sampled at that point, after the edge settles.
module tb_uart_recv_postprocess;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       apb_ren;
  logic [7:0] apb_rdata;
  logic       apb_rvalid;
  logic       apb_clr_err;
  logic [6:0] rx_count;
  logic       rx_overrun;
  logic       rx_ferr;
  logic       irq_rx;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  uart_recv_postprocess #(
    .PTR_WIDTH      (6),
    .FIFO_DEPTH     (64),
    .RX_THRESH      (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .apb_ren      (apb_ren),
    .apb_rdata    (apb_rdata),
    .apb_rvalid   (apb_rvalid),
    .apb_clr_err  (apb_clr_err),
    .rx_count     (rx_count),
    .rx_overrun   (rx_overrun),
    .rx_ferr      (rx_ferr),
    .irq_rx       (irq_rx)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b; rx_frame_err = 1'b0;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pop_byte();
    apb_ren = 1'b1;
    tick();
    apb_ren = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    idle(2);
    sys_rst = 1'b0;
    total_cnt++; if (apb_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b exp 0", apb_rvalid); else pass_cnt++;
    total_cnt++; if (apb_rdata !== 8'h00) $display("FAIL reset_rdata got %h exp 00", apb_rdata); else pass_cnt++;
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL reset_count got %0d exp 0", rx_count); else pass_cnt++;
    total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", rx_overrun); else pass_cnt++;
    total_cnt++; if (rx_ferr !== 1'b0) $display("FAIL reset_ferr got %b exp 0", rx_ferr); else pass_cnt++;
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq_rx); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      push_byte(exp_b[i]);
      idle(2);
    end
    total_cnt++; if (apb_rvalid !== 1'b1) $display("FAIL basic_rvalid got %b exp 1", apb_rvalid); else pass_cnt++;
    total_cnt++; if (rx_count !== 7'd3) $display("FAIL basic_count got %0d exp 3", rx_count); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (apb_rdata !== exp_b[i]) $display("FAIL basic_read%0d got %h exp %h", i, apb_rdata, exp_b[i]);
      else pass_cnt++;
      pop_byte();
    end
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL basic_end_count got %0d exp 0", rx_count); else pass_cnt++;
    total_cnt++; if (apb_rvalid !== 1'b0) $display("FAIL basic_end_rvalid got %b exp 0", apb_rvalid); else pass_cnt++;
    total_cnt++; if (apb_rdata !== 8'h00) $display("FAIL basic_end_rdata got %h exp 00", apb_rdata); else pass_cnt++;
    // Read on an empty FIFO must not underflow.
    pop_byte();
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL empty_pop_count got %0d exp 0", rx_count); else pass_cnt++;
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 65; i++) push_byte(8'(i + 1));
    total_cnt++; if (rx_count !== 7'd64) $display("FAIL ovr_count got %0d exp 64", rx_count); else pass_cnt++;
    total_cnt++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag got %b exp 1", rx_overrun); else pass_cnt++;
    apb_clr_err = 1'b1;
    tick();
    apb_clr_err = 1'b0;
    total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear got %b exp 0", rx_overrun); else pass_cnt++;
    for (int i = 0; i < 64; i++) begin
      total_cnt++;
      if (apb_rdata !== 8'(i + 1)) $display("FAIL ovr_read%0d got %h exp %h", i, apb_rdata, 8'(i + 1));
      else pass_cnt++;
      pop_byte();
    end
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL ovr_drain_count got %0d exp 0", rx_count); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 64; i++) push_byte(8'(8'h80 + i));
    total_cnt++; if (irq_rx !== 1'b1) $display("FAIL full_irq got %b exp 1", irq_rx); else pass_cnt++;
    total_cnt++; if (apb_rdata !== 8'h80) $display("FAIL full_head got %h exp 80", apb_rdata); else pass_cnt++;
    rx_valid = 1'b1; rx_data = 8'h5A; rx_frame_err = 1'b0; apb_ren = 1'b1;
    tick();
    rx_valid = 1'b0; apb_ren = 1'b0;
    total_cnt++; if (rx_count !== 7'd64) $display("FAIL fpp_count got %0d exp 64", rx_count); else pass_cnt++;
    total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL fpp_overrun got %b exp 0", rx_overrun); else pass_cnt++;
    for (int i = 0; i < 63; i++) begin
      total_cnt++;
      if (apb_rdata !== 8'(8'h81 + i)) $display("FAIL fpp_read%0d got %h exp %h", i, apb_rdata, 8'(8'h81 + i));
      else pass_cnt++;
      pop_byte();
    end
    total_cnt++; if (apb_rdata !== 8'h5A) $display("FAIL fpp_last got %h exp 5a", apb_rdata); else pass_cnt++;
    pop_byte();
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL fpp_drain_count got %0d exp 0", rx_count); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    rx_valid = 1'b1; rx_data = 8'hFF; rx_frame_err = 1'b1;
    tick();
    rx_valid = 1'b0; rx_frame_err = 1'b0;
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL ferr_count got %0d exp 0", rx_count); else pass_cnt++;
    total_cnt++; if (rx_ferr !== 1'b1) $display("FAIL ferr_flag got %b exp 1", rx_ferr); else pass_cnt++;
    total_cnt++; if (apb_rvalid !== 1'b0) $display("FAIL ferr_rvalid got %b exp 0", apb_rvalid); else pass_cnt++;
    // Clear and a fresh frame error together: the set wins.
    rx_valid = 1'b1; rx_data = 8'hFF; rx_frame_err = 1'b1; apb_clr_err = 1'b1;
    tick();
    rx_valid = 1'b0; rx_frame_err = 1'b0; apb_clr_err = 1'b0;
    total_cnt++; if (rx_ferr !== 1'b1) $display("FAIL ferr_set_wins got %b exp 1", rx_ferr); else pass_cnt++;
    apb_clr_err = 1'b1;
    tick();
    apb_clr_err = 1'b0;
    total_cnt++; if (rx_ferr !== 1'b0) $display("FAIL ferr_clear got %b exp 0", rx_ferr); else pass_cnt++;
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 7; i++) push_byte(8'(8'h10 + i));
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL thr_below got %b exp 0", irq_rx); else pass_cnt++;
    push_byte(8'h17);
    total_cnt++; if (rx_count !== 7'd8) $display("FAIL thr_count got %0d exp 8", rx_count); else pass_cnt++;
    total_cnt++; if (irq_rx !== 1'b1) $display("FAIL thr_at got %b exp 1", irq_rx); else pass_cnt++;
    pop_byte();
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL thr_pop got %b exp 0", irq_rx); else pass_cnt++;
    for (int i = 0; i < 7; i++) pop_byte();
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL thr_drain_count got %0d exp 0", rx_count); else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic exp_irq;
`ifdef UART_RX_TIMEOUT_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    push_byte(8'hA1);
    push_byte(8'hA2);
    idle(99);
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL tmo_early got %b exp 0", irq_rx); else pass_cnt++;
    idle(1);
    total_cnt++; if (irq_rx !== exp_irq) $display("FAIL tmo_fire got %b exp %b", irq_rx, exp_irq); else pass_cnt++;
    pop_byte();
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL tmo_pop got %b exp 0", irq_rx); else pass_cnt++;
    total_cnt++; if (apb_rdata !== 8'hA2) $display("FAIL tmo_head got %h exp a2", apb_rdata); else pass_cnt++;
    pop_byte();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) push_byte(8'(8'h30 + i));
    rx_valid = 1'b1; rx_data = 8'hEE; rx_frame_err = 1'b1;
    tick();
    rx_valid = 1'b0; rx_frame_err = 1'b0;
    total_cnt++; if (irq_rx !== 1'b1) $display("FAIL mid_pre_irq got %b exp 1", irq_rx); else pass_cnt++;
    total_cnt++; if (rx_ferr !== 1'b1) $display("FAIL mid_pre_ferr got %b exp 1", rx_ferr); else pass_cnt++;
    // Reset with a concurrent push and pop: both must be ignored.
    sys_rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h99; apb_ren = 1'b1;
    tick();
    sys_rst = 1'b0; rx_valid = 1'b0; apb_ren = 1'b0;
    total_cnt++; if (rx_count !== 7'd0) $display("FAIL mid_count got %0d exp 0", rx_count); else pass_cnt++;
    total_cnt++; if (apb_rvalid !== 1'b0) $display("FAIL mid_rvalid got %b exp 0", apb_rvalid); else pass_cnt++;
    total_cnt++; if (apb_rdata !== 8'h00) $display("FAIL mid_rdata got %h exp 00", apb_rdata); else pass_cnt++;
    total_cnt++; if (rx_ferr !== 1'b0) $display("FAIL mid_ferr got %b exp 0", rx_ferr); else pass_cnt++;
    total_cnt++; if (rx_overrun !== 1'b0) $display("FAIL mid_overrun got %b exp 0", rx_overrun); else pass_cnt++;
    total_cnt++; if (irq_rx !== 1'b0) $display("FAIL mid_irq got %b exp 0", irq_rx); else pass_cnt++;
    push_byte(8'h77);
    total_cnt++; if (apb_rdata !== 8'h77) $display("FAIL mid_after_rdata got %h exp 77", apb_rdata); else pass_cnt++;
    total_cnt++; if (rx_count !== 7'd1) $display("FAIL mid_after_count got %0d exp 1", rx_count); else pass_cnt++;
    pop_byte();
  endtask

  initial begin
    sys_rst      = 1'b1;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    rx_frame_err = 1'b0;
    apb_ren      = 1'b0;
    apb_clr_err  = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_frame_err();
    test_threshold();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
